// File: rtl/spi_slave_if.sv
// Pin and core-side signal bundle for one SPI slave channel.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;
    logic                  MISO_oe;
    logic [DATA_WIDTH-1:0] slaveDataToSend;
    logic                  txLoad;
    logic                  txReady;
    logic [DATA_WIDTH-1:0] slaveDataReceived;
    logic                  rxValid;
    logic                  txUnderrun;
    logic                  frameAbort;
    logic                  busy;

    modport slave (
        input  SCLK, CS, MOSI, slaveDataToSend, txLoad,
        output MISO, MISO_oe, txReady, slaveDataReceived, rxValid,
               txUnderrun, frameAbort, busy
    );

    modport master (
        output SCLK, CS, MOSI, slaveDataToSend, txLoad,
        input  MISO, MISO_oe, txReady, slaveDataReceived, rxValid,
               txUnderrun, frameAbort, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave (mode 0, MSB first) oversampled on clk, with a one-deep
// transmit shadow register and a parallel receive port.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d;
    logic [DATA_WIDTH-1:0]  r_tx_sh, r_rx_sh, r_shadow, r_rx_data;
    logic                   r_shadow_full;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_first, r_udr_pend;
    logic                   r_miso, r_rx_valid, r_underrun, r_abort;

    logic w_sclk, w_cs, w_mosi;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_busy, w_start, w_stop, w_sample, w_shift, w_done, w_tx_load;
    logic w_can_capture;
    logic [DATA_WIDTH-1:0] w_rx_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= SYNC_STAGES'({r_sclk_sync, bus.SCLK});
            r_cs_sync   <= SYNC_STAGES'({r_cs_sync, bus.CS});
            r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, bus.MOSI});
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // CS deselect takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                w_busy = 1'b1;
                if (w_cs_rise) begin
                    w_stop      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_sample = w_sclk_rise;
                    w_shift  = w_sclk_fall;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_done        = w_sample && (r_bit_cnt == CW'(DATA_WIDTH-1));
    assign w_tx_load     = w_start || w_done;
    assign w_can_capture = !r_shadow_full || w_tx_load;
    assign w_rx_next     = {r_rx_sh[DATA_WIDTH-2:0], w_mosi};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_sh       <= '0;
            r_rx_sh       <= '0;
            r_rx_data     <= '0;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_bit_cnt     <= '0;
            r_first       <= 1'b0;
            r_udr_pend    <= 1'b0;
            r_miso        <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_underrun    <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;

            if (bus.txLoad && w_can_capture) begin
                r_shadow      <= bus.slaveDataToSend;
                r_shadow_full <= 1'b1;
            end else if (w_tx_load) begin
                r_shadow_full <= 1'b0;
            end

            if (w_tx_load) r_tx_sh <= r_shadow_full ? r_shadow : '0;

            if (w_start) begin
                r_miso     <= r_shadow_full ? r_shadow[DATA_WIDTH-1] : 1'b0;
                r_underrun <= !r_shadow_full;
                r_bit_cnt  <= '0;
                r_first    <= 1'b0;
                r_udr_pend <= 1'b0;
            end

            // A reload at a byte boundary only counts as an underrun once the
            // next byte actually begins clocking.
            if (w_sample) begin
                r_rx_sh <= w_rx_next;
                if (r_bit_cnt == '0 && r_udr_pend) begin
                    r_underrun <= 1'b1;
                    r_udr_pend <= 1'b0;
                end
                if (w_done) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_first    <= 1'b1;
                    r_udr_pend <= !r_shadow_full;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            // The first fall after a boundary reload presents bit 7 unshifted.
            if (w_shift) begin
                if (r_first) begin
                    r_miso  <= r_tx_sh[DATA_WIDTH-1];
                    r_first <= 1'b0;
                end else begin
                    r_tx_sh <= r_tx_sh << 1;
                    r_miso  <= r_tx_sh[DATA_WIDTH-2];
                end
            end

            if (w_stop) begin
                r_abort    <= (r_bit_cnt != '0);
                r_bit_cnt  <= '0;
                r_first    <= 1'b0;
                r_udr_pend <= 1'b0;
                r_miso     <= 1'b0;
            end
        end
    end

    assign bus.MISO              = r_miso;
    assign bus.MISO_oe           = w_busy;
    assign bus.busy              = w_busy;
    assign bus.txReady           = !r_shadow_full;
    assign bus.slaveDataReceived = r_rx_data;
    assign bus.rxValid           = r_rx_valid;
    assign bus.txUnderrun        = r_underrun;
    assign bus.frameAbort        = r_abort;
endmodule

// File: doc/spi_slave.md
# spi_slave

Single-channel SPI slave: the responder end of the team's SPI master link. One instance sits behind each `CS` line.
- Oversamples `SCLK`, `CS` and `MOSI` on the local system clock.
- Shifts 8-bit frames MSB-first in both directions.
- Presents received bytes and accepts outgoing bytes through a parallel valid/ready-style interface to the local core.

## Interface
Parameters:
- `DATA_WIDTH`, 8: frame length in bits.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `SCLK`, `CS`, `MOSI`.

Ports:
- `clk`  in  1  system clock; must run at ≥ 8× the `SCLK` frequency.
- `reset`  in  1  asynchronous, active-low reset.
- `SCLK`  in  1  serial clock from master; asynchronous to `clk`.
- `CS`  in  1  this slave's chip select, active low.
- `MOSI`  in  1  serial data from master.
- `MISO`  out  1  serial data to master.
- `MISO_oe`  out  1  output enable for the `MISO` pad; high only while selected.
- `slaveDataToSend`  in  `DATA_WIDTH`  next byte to transmit.
- `txLoad`  in  1  strobe: capture `slaveDataToSend` when `txReady` = 1.
- `txReady`  out  1  transmit shadow register empty.
- `slaveDataReceived`  out  `DATA_WIDTH`  last complete received byte.
- `rxValid`  out  1  one-cycle pulse: `slaveDataReceived` updated.
- `txUnderrun`  out  1  one-cycle pulse: a byte started with the shadow empty.
- `frameAbort`  out  1  one-cycle pulse: `CS` deasserted mid-byte.
- `busy`  out  1  high while selected.

## Operation
Synchronization:
- `SCLK`, `CS` and `MOSI` each pass through `SYNC_STAGES` flops.
- A one-flop edge detector on synchronized `SCLK` and `CS` produces rise/fall strobes.

State machine, two states:
- IDLE: `busy` = 0, `MISO_oe` = 0.
  - On `CS` fall strobe: load the tx shift register from the shadow, drive `MISO` = bit 7, set `bitCount` = 0, go to ACTIVE.
- ACTIVE: `busy` = 1, `MISO_oe` = 1.
  - `SCLK` rise strobe: shift the synchronized `MOSI` into the rx shift register LSB (left shift); `bitCount` += 1.
  - `SCLK` fall strobe: left-shift the tx register; `MISO` = new bit 7.
  - `bitCount` reaches `DATA_WIDTH` on a rise strobe:
    - `slaveDataReceived` ← assembled byte; pulse `rxValid`.
    - `bitCount` ← 0.
    - Reload the tx register from the shadow for the next back-to-back byte. The new bit 7 goes out on the following fall strobe.
  - `CS` rise strobe: go to IDLE.
    - If `bitCount` ≠ 0: discard the partial byte, pulse `frameAbort`, no `rxValid`.
    - The tx shadow keeps its state if it was not consumed.

Transmit shadow:
- `txLoad` while `txReady` = 1: capture `slaveDataToSend`, `txReady` ← 0.
- `txLoad` while `txReady` = 0: ignored; the shadow is not overwritten.
- Shadow consumed at a tx-register load: `txReady` ← 1 in the same cycle.
- Tx-register load with the shadow empty: load 8'h00 and pulse `txUnderrun`.
- `txLoad` in the same cycle as a consuming load: the load completes first, then the new byte is captured (`txReady` stays 0).

Simultaneous events:
- `CS` rise strobe and `SCLK` rise strobe in the same cycle: `CS` wins. The bit is not sampled; abort rules apply.

## Timing
Reset values (asynchronous, while `reset` = 0):
- `MISO` = 0, `MISO_oe` = 0, `busy` = 0, `txReady` = 1.
- `slaveDataReceived` = 0, `rxValid` = 0, `txUnderrun` = 0, `frameAbort` = 0.
- Shift registers, `bitCount` and synchronizers cleared.
- State = IDLE.

Latency and placement:
- Pin edge to internal strobe: `SYNC_STAGES` + 1 `clk` cycles (3 at default).
- `MISO` first bit valid 3 cycles after the `CS` pin falls; the master must wait ≥ 4 `clk` before the first `SCLK` rise.
- `rxValid` asserts 3 cycles after the 8th `SCLK` pin rise and is high for exactly 1 cycle.
- `MISO` changes 3 cycles after each `SCLK` fall. The `clk` ≥ 8× `SCLK` requirement keeps this ≥ 1 cycle before the master's next sampling rise.
- Reset asserted mid-frame: immediate return to reset values, no pulses.

## Test plan
- Load 8'hA5 via `txLoad`, master sends 8'h3C with `CS` low → `MISO` shifts out 1010_0101; `slaveDataReceived` = 8'h3C with one `rxValid` pulse; `txReady` back to 1 at the `CS` fall.
- Two back-to-back bytes under one `CS` (tx 8'h11 then 8'h22 loaded after the first `txReady`; rx 8'hF0, 8'h0F) → two `rxValid` pulses with those values; `MISO` carries 8'h11 then 8'h22; no `txUnderrun`.
- `CS` low with no `txLoad` → `MISO` sends 8'h00; `txUnderrun` pulses once at the `CS` fall.
- Master sends 5 bits, then `CS` rises → `frameAbort` one pulse; no `rxValid`; `slaveDataReceived` unchanged; next full frame 8'h81 received correctly.
- Second `txLoad` (8'hEE) while `txReady` = 0 after loading 8'h55 → transmitted byte is 8'h55.
- Assert `reset` after 4 bits of a frame → all outputs at reset values; after release, a new frame 8'hC3 is received correctly.
